// File: rtl/round_sequencer.sv
// round_sequencer: drives an external card-round FSM with deal ticks and resets,
// tallies round results, enforces a round cap and detects stalled rounds.
module round_sequencer #(
    parameter int unsigned TICK_DIV   = 25000000,
    parameter int unsigned HOLD_TICKS = 4,
    parameter int unsigned DEAL_LIMIT = 8,
    parameter int unsigned MAX_ROUNDS = 0
) (
    input  logic       clk,
    input  logic       resetb,
    input  logic       run,
    input  logic       step_req,
    input  logic       clr,
    input  logic       player_win_light,
    input  logic       dealer_win_light,
    output logic       deal_tick,
    output logic       round_resetb,
    output logic       busy,
    output logic       fault,
    output logic       done,
    output logic [7:0] p_wins,
    output logic [7:0] d_wins,
    output logic [7:0] ties,
    output logic [7:0] rounds
);
    localparam logic [31:0] DIV_LAST  = 32'(TICK_DIV - 1);
    localparam logic [31:0] HOLD_LAST = 32'(HOLD_TICKS * TICK_DIV - 1);
    localparam logic [31:0] TICK_MAX  = 32'(DEAL_LIMIT);
    localparam logic [31:0] ROUND_CAP = 32'(MAX_ROUNDS);

    typedef enum logic [2:0] {IDLE, RRST, DEAL, RECORD, HOLD, FAULT} state_t;

    state_t      state;
    logic [31:0] div_cnt;
    logic [31:0] hold_cnt;
    logic [31:0] tick_cnt;
    logic        rrst_cnt;
    logic        step_q;
    logic [1:0]  result;
    logic [1:0]  lights;
    logic        step_rise;

    assign lights    = {player_win_light, dealer_win_light};
    assign step_rise = step_req & ~step_q;

    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            state        <= IDLE;
            div_cnt      <= '0;
            hold_cnt     <= '0;
            tick_cnt     <= '0;
            rrst_cnt     <= 1'b0;
            step_q       <= 1'b0;
            result       <= '0;
            deal_tick    <= 1'b0;
            round_resetb <= 1'b0;
            busy         <= 1'b0;
            fault        <= 1'b0;
            done         <= 1'b0;
            p_wins       <= '0;
            d_wins       <= '0;
            ties         <= '0;
            rounds       <= '0;
        end else begin
            step_q    <= step_req;
            deal_tick <= 1'b0;
            case (state)
                IDLE: begin
                    if (clr) begin
                        p_wins <= '0;
                        d_wins <= '0;
                        ties   <= '0;
                        rounds <= '0;
                        done   <= 1'b0;
                    end
                    if ((run && !done) || step_rise) begin
                        state    <= RRST;
                        rrst_cnt <= 1'b0;
                        busy     <= 1'b1;
                    end
                end
                RRST: begin
                    rrst_cnt <= 1'b1;
                    if (rrst_cnt) begin
                        state        <= DEAL;
                        div_cnt      <= '0;
                        tick_cnt     <= '0;
                        round_resetb <= 1'b1;
                    end
                end
                DEAL: begin
                    // A result seen on a wrap cycle wins: no tick is issued for it.
                    if (lights != 2'b00) begin
                        state  <= RECORD;
                        result <= lights;
                    end else if (div_cnt == DIV_LAST) begin
                        div_cnt <= '0;
                        if (tick_cnt == TICK_MAX) begin
                            state        <= FAULT;
                            fault        <= 1'b1;
                            round_resetb <= 1'b0;
                        end else begin
                            deal_tick <= 1'b1;
                            tick_cnt  <= tick_cnt + 32'd1;
                        end
                    end else begin
                        div_cnt <= div_cnt + 32'd1;
                    end
                end
                RECORD: begin
                    case (result)
                        2'b10:   p_wins <= sat_inc(p_wins);
                        2'b01:   d_wins <= sat_inc(d_wins);
                        2'b11:   ties   <= sat_inc(ties);
                        default: ;
                    endcase
                    rounds   <= sat_inc(rounds);
                    state    <= HOLD;
                    hold_cnt <= '0;
                end
                HOLD: begin
                    if (hold_cnt == HOLD_LAST) begin
                        round_resetb <= 1'b0;
                        if (ROUND_CAP != '0 && {24'd0, rounds} >= ROUND_CAP) begin
                            done  <= 1'b1;
                            state <= IDLE;
                            busy  <= 1'b0;
                        end else if (run) begin
                            state    <= RRST;
                            rrst_cnt <= 1'b0;
                        end else begin
                            state <= IDLE;
                            busy  <= 1'b0;
                        end
                    end else begin
                        hold_cnt <= hold_cnt + 32'd1;
                    end
                end
                FAULT: begin
                    if (!run && !step_req) begin
                        state <= IDLE;
                        fault <= 1'b0;
                        busy  <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_round_sequencer.sv
// Randomized scoreboard bench for round_sequencer with a behavioural model of
// the external round FSM and of the expected tallies per play session.
module tb_round_sequencer;
    localparam int TD = 4;
    localparam int HT = 2;
    localparam int DL = 8;
    localparam int MR = 3;

    logic clk = 1'b0;
    logic resetb = 1'b0, run = 1'b0, step_req = 1'b0, clr = 1'b0;
    logic pwl, dwl;
    logic deal_tick, round_resetb, busy, fault, done;
    logic [7:0] p_wins, d_wins, ties, rounds;

    int n_checks = 0;
    int n_fail = 0;

    typedef struct { int ticks; int delay; logic [1:0] outcome; bit is_fault; } plan_t;
    typedef struct { int p; int d; int t; int r; bit done; bit fault; } sess_t;

    plan_t plan_q[$];
    sess_t sess_q[$];
    int mp = 0, md = 0, mt = 0, mr = 0;
    bit mdone = 1'b0;

    round_sequencer #(.TICK_DIV(TD), .HOLD_TICKS(HT), .DEAL_LIMIT(DL), .MAX_ROUNDS(MR)) dut (
        .clk(clk), .resetb(resetb), .run(run), .step_req(step_req), .clr(clr),
        .player_win_light(pwl), .dealer_win_light(dwl),
        .deal_tick(deal_tick), .round_resetb(round_resetb), .busy(busy), .fault(fault),
        .done(done), .p_wins(p_wins), .d_wins(d_wins), .ties(ties), .rounds(rounds)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic timeout_fail(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s: timed out waiting for DUT (t=%0t)", name, $time);
    endtask

    // External round FSM: counts deal ticks and lights the planned result.
    logic [1:0] lights_m;
    logic prev_rr;
    int rm_ticks, rm_dly;
    bit rm_pend;
    plan_t cur;
    assign pwl = lights_m[1];
    assign dwl = lights_m[0];

    always @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            lights_m <= 2'b00;
            prev_rr  <= 1'b0;
            rm_ticks <= 0;
            rm_pend  <= 1'b0;
        end else begin
            prev_rr <= round_resetb;
            if (!round_resetb) begin
                lights_m <= 2'b00;
                rm_pend  <= 1'b0;
            end else if (!prev_rr) begin
                check("plan_available", int'(plan_q.size() > 0), 1);
                if (plan_q.size() > 0) cur = plan_q.pop_front();
                else cur = '{ticks: 0, delay: 0, outcome: 2'b00, is_fault: 1'b1};
                rm_ticks <= 0;
            end else begin
                if (deal_tick) begin
                    rm_ticks <= rm_ticks + 1;
                    if (!cur.is_fault && rm_ticks + 1 == cur.ticks) begin
                        if (cur.delay == 0) lights_m <= cur.outcome;
                        else begin
                            rm_dly  <= cur.delay;
                            rm_pend <= 1'b1;
                        end
                    end
                end
                if (rm_pend) begin
                    if (rm_dly == 1) begin
                        lights_m <= cur.outcome;
                        rm_pend  <= 1'b0;
                    end else rm_dly <= rm_dly - 1;
                end
            end
        end
    end

    // Monitor: per-round timing checks and per-session scoreboard pops.
    int ncyc = 0, cyc = 0, rticks = 0, light_t = 0;
    bit lseen = 1'b0, prev_busy = 1'b0, prev_rr_m = 1'b0, fault_seen = 1'b0;

    always @(negedge clk) begin
        ncyc++;
        if (!resetb) begin
            prev_busy  = 1'b0;
            prev_rr_m  = 1'b0;
            fault_seen = 1'b0;
            lseen      = 1'b0;
        end else begin
            if (busy && fault) fault_seen = 1'b1;
            if (round_resetb && !prev_rr_m) begin
                cyc = 0;
                rticks = 0;
                lseen = 1'b0;
            end else if (round_resetb) cyc++;
            if (deal_tick) begin
                rticks++;
                check("tick_timing", cyc, rticks * TD);
            end
            if (round_resetb && !lseen && (pwl || dwl)) begin
                lseen = 1'b1;
                light_t = ncyc;
            end
            if (!round_resetb && prev_rr_m) begin
                check("round_fault_flag", int'(fault), int'(cur.is_fault));
                check("round_tick_count", rticks, cur.is_fault ? DL : cur.ticks);
                if (lseen) check("hold_length", ncyc - light_t, HT * TD + 2);
            end
            if (!busy && prev_busy) begin
                if (sess_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL session_expected: DUT went idle with no session queued");
                end else begin
                    sess_t e;
                    e = sess_q.pop_front();
                    check("p_wins", int'(p_wins), e.p);
                    check("d_wins", int'(d_wins), e.d);
                    check("ties", int'(ties), e.t);
                    check("rounds", int'(rounds), e.r);
                    check("done", int'(done), int'(e.done));
                    check("fault_seen", int'(fault_seen), int'(e.fault));
                end
                fault_seen = 1'b0;
            end
            prev_busy = busy;
            prev_rr_m = round_resetb;
        end
    end

    function automatic int sat(input int v);
        return (v < 255) ? v + 1 : 255;
    endfunction

    task automatic model_round(input plan_t p);
        if (!p.is_fault) begin
            if (p.outcome == 2'b10) mp = sat(mp);
            else if (p.outcome == 2'b01) md = sat(md);
            else mt = sat(mt);
            mr = sat(mr);
            if (mr >= MR) mdone = 1'b1;
        end
    endtask

    task automatic model_clear();
        mp = 0; md = 0; mt = 0; mr = 0; mdone = 1'b0;
    endtask

    task automatic push_plan(input logic [1:0] oc, input int ticks, input int dly, input bit f);
        plan_t p;
        p.ticks = ticks; p.delay = dly; p.outcome = oc; p.is_fault = f;
        plan_q.push_back(p);
        model_round(p);
    endtask

    task automatic push_sess(input bit f);
        sess_q.push_back('{mp, md, mt, mr, mdone, f});
    endtask

    task automatic wait_busy(input string name, input logic level, input int limit);
        int k = 0;
        while (busy !== level && k < limit) begin
            @(negedge clk);
            k++;
        end
        if (busy !== level) timeout_fail(name);
    endtask

    task automatic oneshot(input logic [1:0] oc, input int ticks, input int dly,
                           input bit f, input bit with_clr);
        if (with_clr) model_clear();
        push_plan(oc, ticks, dly, f);
        push_sess(f);
        @(negedge clk); step_req = 1'b1; clr = with_clr;
        @(negedge clk); clr = 1'b0;
        @(negedge clk); step_req = 1'b0;
        wait_busy("oneshot_start", 1'b1, 20);
        wait_busy("oneshot_end", 1'b0, 500);
        repeat (2) @(negedge clk);
    endtask

    task automatic clear_tallies();
        @(negedge clk); clr = 1'b1;
        @(negedge clk); clr = 1'b0;
        model_clear();
        check("clr_p_wins", int'(p_wins), 0);
        check("clr_rounds", int'(rounds), 0);
        check("clr_done", int'(done), 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int seen, k;
        bit busy_any;
        repeat (3) @(negedge clk);
        check("rst_deal_tick", int'(deal_tick), 0);
        check("rst_round_resetb", int'(round_resetb), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_fault", int'(fault), 0);
        check("rst_done", int'(done), 0);
        check("rst_tallies", int'({p_wins, d_wins, ties, rounds}), 0);
        resetb = 1'b1;
        repeat (2) @(negedge clk);

        // Player win after the 4th tick.
        oneshot(2'b10, 4, 0, 1'b0, 1'b0);

        // Run mode capped at three rounds.
        clear_tallies();
        push_plan(2'b01, $urandom_range(1, 8), $urandom_range(0, 2), 1'b0);
        push_plan(2'b11, $urandom_range(1, 8), $urandom_range(0, 2), 1'b0);
        push_plan(2'b01, $urandom_range(1, 8), $urandom_range(0, 2), 1'b0);
        push_sess(1'b0);
        @(negedge clk); run = 1'b1;
        wait_busy("run_start", 1'b1, 20);
        wait_busy("run_end", 1'b0, 1500);
        busy_any = 1'b0;
        repeat (30) begin
            @(negedge clk);
            busy_any |= busy;
        end
        check("no_round_after_cap", int'(busy_any), 0);
        run = 1'b0;

        // Stalled round: lights never come on.
        clear_tallies();
        push_plan(2'b00, 0, 0, 1'b1);
        push_sess(1'b1);
        @(negedge clk); run = 1'b1;
        k = 0;
        while (!fault && k < 200) begin
            @(negedge clk);
            k++;
        end
        check("fault_raised", int'(fault), 1);
        repeat (5) @(negedge clk);
        check("fault_held_with_run", int'(fault), 1);
        run = 1'b0;
        wait_busy("fault_exit", 1'b0, 20);
        repeat (2) @(negedge clk);

        // Result lands exactly on a divider wrap.
        oneshot(2'b10, 2, 2, 1'b0, 1'b0);
        oneshot(2'b11, 8, 2, 1'b0, 1'b0);
        // Clear concurrent with a round start.
        oneshot(2'b01, 3, 1, 1'b0, 1'b1);

        for (int i = 0; i < 24; i++) begin
            logic [1:0] oc;
            oc = 2'($urandom_range(1, 3));
            oneshot(oc, $urandom_range(1, 8), $urandom_range(0, 2),
                    $urandom_range(0, 7) == 0, $urandom_range(0, 9) == 0);
        end

        // Saturate p_wins and rounds.
        for (int i = 0; i < 256; i++) oneshot(2'b10, 1, 0, 1'b0, 1'b0);
        check("p_wins_saturated", int'(p_wins), 255);

        // Asynchronous reset in the middle of DEAL.
        push_plan(2'b10, 6, 0, 1'b0);
        @(negedge clk); step_req = 1'b1;
        @(negedge clk);
        @(negedge clk); step_req = 1'b0;
        seen = 0;
        k = 0;
        while (seen < 2 && k < 200) begin
            @(negedge clk);
            if (deal_tick) seen++;
            k++;
        end
        if (seen < 2) timeout_fail("abort_ticks");
        @(posedge clk);
        #3 resetb = 1'b0;
        #1;
        check("abort_round_resetb", int'(round_resetb), 0);
        check("abort_busy", int'(busy), 0);
        check("abort_deal_tick", int'(deal_tick), 0);
        check("abort_tallies", int'({p_wins, d_wins, ties, rounds}), 0);
        check("abort_done", int'(done), 0);
        model_clear();
        repeat (2) @(negedge clk);
        resetb = 1'b1;
        repeat (3) @(negedge clk);
        oneshot(2'b01, 3, 1, 1'b0, 1'b0);

        check("sessions_drained", sess_q.size(), 0);
        check("plans_drained", plan_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/round_sequencer.md
ROUND_SEQUENCER -- requirements
Module: round_sequencer

Interface
REQ-001 Parameter TICK_DIV, default 25000000, clk cycles per deal_tick interval (min 2).
REQ-002 Parameter HOLD_TICKS, default 4, tick intervals the result is held before the next round (min 1).
REQ-003 Parameter DEAL_LIMIT, default 8, maximum deal_ticks per round before fault.
REQ-004 Parameter MAX_ROUNDS, default 0, round cap in run mode; 0 = unlimited.
REQ-005 clk  in  1  system clock; all logic rising-edge.
REQ-006 resetb  in  1  reset, asynchronous, active-low.
REQ-007 run  in  1  level; 1 = play rounds continuously.
REQ-008 step_req  in  1  level, already synchronised; each rising edge in IDLE requests one round.
REQ-009 clr  in  1  synchronous tally clear, honoured in IDLE only.
REQ-010 player_win_light, dealer_win_light  in  1 each  round-FSM result lights; any nonzero = round finished; 11 = tie.
REQ-011 deal_tick  out  1  one-cycle pulse advancing the round FSM one step.
REQ-012 round_resetb  out  1  active-low reset driven to the round FSM.
REQ-013 busy  out  1  high in any state other than IDLE.
REQ-014 fault  out  1  high in FAULT.
REQ-015 done  out  1  sticky; high once the MAX_ROUNDS cap is reached.
REQ-016 p_wins, d_wins, ties, rounds  out  8 each  saturating tallies.

Function
REQ-017 States: IDLE, RRST, DEAL, RECORD, HOLD, FAULT.
REQ-018 IDLE: round_resetb=0; exit to RRST when run=1 and done=0, or on a step_req rising edge (one-shot round).
REQ-019 RRST: round_resetb=0 for exactly 2 cycles, then DEAL; divider cleared on entry to DEAL.
REQ-020 DEAL: round_resetb=1; divider counts 0..TICK_DIV-1; deal_tick pulses when count==TICK_DIV-1; first pulse exactly TICK_DIV cycles after DEAL entry.
REQ-021 DEAL: lights checked every cycle; nonzero lights -> RECORD next cycle, and no deal_tick in that cycle even if the divider wraps.
REQ-022 DEAL: if DEAL_LIMIT ticks have issued and lights are still 00 at the next wrap -> FAULT; no further tick.
REQ-023 RECORD (1 cycle): lights 10 -> p_wins+1; 01 -> d_wins+1; 11 -> ties+1; rounds+1 always; all tallies saturate at 255.
REQ-024 HOLD: round_resetb=1, deal_tick=0; lasts HOLD_TICKS*TICK_DIV cycles.
REQ-025 HOLD exit: if MAX_ROUNDS!=0 and rounds>=MAX_ROUNDS, set done and go to IDLE; else if run=1 -> RRST; else -> IDLE.
REQ-026 A one-shot round (run=0) plays exactly one round and returns to IDLE after HOLD.
REQ-027 run deasserted mid-round: the current round completes, including RECORD and HOLD, then IDLE.
REQ-028 run asserted during a one-shot round: continuous play follows HOLD.
REQ-029 step_req edges outside IDLE are ignored and not queued; the edge detector keeps tracking in all states.
REQ-030 FAULT: round_resetb=0, fault=1, tallies frozen; exit to IDLE only when run=0 and step_req=0.
REQ-031 clr in IDLE clears all tallies and done in the next cycle; clr is ignored in other states.
REQ-032 clr concurrent with an IDLE exit condition: clear takes effect and the FSM still exits.
REQ-033 All outputs are registered; no combinational path from inputs to outputs.

Reset
REQ-034 resetb=0 forces IDLE; divider, tallies, done, fault = 0; deal_tick=0; round_resetb=0; busy=0; step edge detector history = 0.
REQ-035 resetb asserted mid-round aborts the round immediately with no tally update; operation resumes from IDLE after release.

Verification (TICK_DIV=4, HOLD_TICKS=2, DEAL_LIMIT=8)
REQ-036 step_req pulse; lights go 10 after the 4th tick -> ticks at 4, 8, 12, 16 cycles after DEAL entry; p_wins=1, rounds=1; HOLD 8 cycles; IDLE.
REQ-037 run=1, MAX_ROUNDS=3; lights alternate 01, 11, 01 -> d_wins=2, ties=1, rounds=3, done=1; IDLE; no 4th RRST.
REQ-038 lights held 00 -> exactly 8 deal_ticks, then fault=1; release run -> IDLE; tallies unchanged.
REQ-039 Lights go nonzero on the cycle the divider wraps -> no deal_tick that cycle; RECORD next cycle.
REQ-040 Force p_wins to 255, play a player-win round -> p_wins stays 255; rounds increments.
REQ-041 resetb pulsed during DEAL -> all outputs at reset values asynchronously; no tally change.
